mips_multicycle_ctrl: RTL

Multi-cycle sequencer for the five-instruction Harvard MIPS core (ADDU, ADDIU, LW, SW, JR). It owns the PC, the instruction register and the ALU operand/result registers. Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB, driving the ALU, register file and both memory ports. It sits between the instruction memory, data memory, register file and the combinational ALU, and is the only block with architectural sequential state apart from the register file.

---
 rtl/mips_multicycle_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for a five-instruction MIPS core (ADDU, ADDIU, LW, SW, JR).
// Owns PC, IR and the ALU operand/result registers; drives fetch, data, regfile and ALU.
module mips_multicycle_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic        data_waitrequest,
  input  logic [31:0] data_readdata,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [31:0] reg_wdata,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_func,
  input  logic [31:0] alu_out,
  output logic        active,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, pc_next_q, ir_q, a_q, b_q, aluout_q, mdr_q;
  logic        fault_q;

  logic [5:0]         opcode, func;
  logic               is_addu, is_jr, is_addiu, is_lw, is_sw, is_mem, legal, misaligned;
  logic signed [31:0] imm_sext;

  assign opcode   = ir_q[31:26];
  assign func     = ir_q[5:0];
  assign is_addu  = (opcode == 6'b000000) && (func == 6'b100001);
  assign is_jr    = (opcode == 6'b000000) && (func == 6'b001000);
  assign is_addiu = (opcode == 6'b001001);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_mem   = is_lw | is_sw;
  assign legal    = is_addu | is_jr | is_addiu | is_lw | is_sw;
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign misaligned = is_mem && (alu_out[1:0] != 2'b00);

  // JR reuses the ADDU path with a zero second operand so the ALU forms A + 0.
  always_comb begin
    alu_op2 = b_q;
    if (is_jr)
      alu_op2 = '0;
    else if (is_addiu | is_mem)
      alu_op2 = imm_sext;
  end

  assign alu_op1    = a_q;
  assign alu_opcode = opcode;
  assign alu_func   = is_jr ? 6'b100001 : func;
  assign rs_addr    = ir_q[25:21];
  assign rt_addr    = ir_q[20:16];

  // Requests decode straight from registered state, so they hold steady across wait cycles.
  assign instr_address  = pc_q;
  assign instr_read     = !reset && (state_q == S_FETCH) && (pc_q != '0);
  assign data_address   = aluout_q;
  assign data_writedata = b_q;
  assign data_read      = (state_q == S_MEM) && is_lw;
  assign data_write     = (state_q == S_MEM) && is_sw;
  assign reg_waddr      = is_addu ? ir_q[15:11] : ir_q[20:16];
  assign reg_wdata      = is_lw ? mdr_q : aluout_q;
  assign reg_we         = (state_q == S_WB) && (reg_waddr != 5'd0);
  assign active         = (state_q != S_HALT);
  assign fault          = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      pc_next_q <= RESET_VECTOR + 32'd4;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (pc_q == '0) begin
            state_q <= S_HALT;
          end else if (!instr_waitrequest) begin
            ir_q      <= instr_readdata;
            pc_q      <= pc_next_q;
            pc_next_q <= pc_next_q + 32'd4;
            state_q   <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q <= rs_data;
          b_q <= rt_data;
          if (legal) begin
            state_q <= S_EXEC;
          end else begin
            fault_q <= 1'b1;
            state_q <= S_HALT;
          end
        end
        S_EXEC: begin
          aluout_q <= alu_out;
          // PC already points at the delay slot; only the following fetch is redirected.
          if (is_jr) begin
            pc_next_q <= a_q;
            state_q   <= S_FETCH;
          end else if (misaligned) begin
            fault_q <= 1'b1;
            state_q <= S_HALT;
          end else if (is_mem) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (!data_waitrequest) begin
            if (is_lw) begin
              mdr_q   <= data_readdata;
              state_q <= S_WB;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_HALT;
      endcase
    end
  end

endmodule
